mem_fill_check: RTL

Self-test sequencer that sits directly upstream of the registered-input 32x3 single-port RAM stage. On `start` it drives the RAM's `address`/`dataIn`/`write` to fill all 32 words with a seeded pattern, then reads every word back and compares the RAM's `dataOut` against the expected value. It accounts for the RAM stage's read latency and reports pass/fail, an error count and the first failing address. It is the board-level exerciser for the memory stage and the stimulus source for its system-level bench.

---
 rtl/mem_check_pkg.sv | 24 ++
 rtl/check_delay.sv | 47 ++++
 rtl/mem_fill_check.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_check_pkg.sv
// Shared types, default geometry and the fill-pattern function for the RAM self-test.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_check_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 3;
  localparam int RD_LAT = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    READ  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Pattern word for an address: low 3 address bits plus bits [4:3] plus seed, wrapping.
  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0] seed);
    return DATA_W'(addr[2:0]) + DATA_W'(addr[4:3]) + seed;
  endfunction

endpackage

// File: rtl/check_delay.sv
// Delay line that carries {valid, addr, expected} alongside the RAM's read pipeline.
// Latency: RD_LAT cycles from input to output.
// Backpressure: none; shifts every cycle, synchronous reset empties it.
module check_delay #(
  parameter int ADDR_W = mem_check_pkg::ADDR_W,
  parameter int DATA_W = mem_check_pkg::DATA_W,
  parameter int RD_LAT = mem_check_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vld_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_exp_i,
  output logic              out_vld_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_exp_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [DATA_W-1:0] exp_q  [RD_LAT];

  // Shift tags one stage per cycle; reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      vld_q[0]  <= in_vld_i;
      addr_q[0] <= in_addr_i;
      exp_q[0]  <= in_exp_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
    end
  end

  assign out_vld_o  = vld_q[RD_LAT-1];
  assign out_addr_o = addr_q[RD_LAT-1];
  assign out_exp_o  = exp_q[RD_LAT-1];

endmodule

// File: rtl/mem_fill_check.sv
// Fills a 32-word RAM with a seeded pattern, reads it back and counts mismatches.
// Latency: done rises 65+RD_LAT cycles after start is accepted; all outputs registered.
// Backpressure: none; start is ignored while busy, the RAM is assumed always ready.
module mem_fill_check #(
  parameter int ADDR_W = mem_check_pkg::ADDR_W,
  parameter int DATA_W = mem_check_pkg::DATA_W,
  parameter int RD_LAT = mem_check_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] dataOut,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataIn,
  output logic              write,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr
);
  import mem_check_pkg::*;

  localparam int FL_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
  localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              write_q, write_d;
  logic              rd_q, rd_d;
  logic [FL_W-1:0]   flush_q, flush_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W:0]   err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;

  logic [DATA_W-1:0] rd_exp;
  logic              tag_vld;
  logic [ADDR_W-1:0] tag_addr;
  logic [DATA_W-1:0] tag_exp;

  // The tag is launched from the registered bus, so it lines up with the RAM's input flop.
  assign rd_exp = exp_data(address_q, seed_q);

  check_delay #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_check_delay (
    .clk        (clk),
    .reset      (reset),
    .in_vld_i   (rd_q),
    .in_addr_i  (address_q),
    .in_exp_i   (rd_exp),
    .out_vld_o  (tag_vld),
    .out_addr_o (tag_addr),
    .out_exp_o  (tag_exp)
  );

  // Next state, next bus values and result accumulation.
  always_comb begin
    state_d   = state_q;
    address_d = '0;
    data_in_d = '0;
    write_d   = 1'b0;
    rd_d      = 1'b0;
    flush_d   = '0;
    seed_d    = seed_q;
    err_d     = err_q;
    first_d   = first_q;

    if (tag_vld && (dataOut != tag_exp)) begin
      err_d = err_q + (ADDR_W+1)'(1);
      if (err_q == '0) begin
        first_d = tag_addr;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = FILL;
          seed_d    = seed;
          err_d     = '0;
          first_d   = '0;
          write_d   = 1'b1;
          data_in_d = exp_data('0, seed);
        end
      end
      FILL: begin
        if (address_q == ADDR_MAX) begin
          state_d = READ;
          rd_d    = 1'b1;
        end else begin
          address_d = address_q + ADDR_W'(1);
          write_d   = 1'b1;
          data_in_d = exp_data(address_q + ADDR_W'(1), seed_q);
        end
      end
      READ: begin
        if (address_q == ADDR_MAX) begin
          state_d = FLUSH;
        end else begin
          address_d = address_q + ADDR_W'(1);
          rd_d      = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_q == FLUSH_LAST) begin
          state_d = DONE;
        end else begin
          flush_d = flush_q + FL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == FILL) || (state_d == READ) || (state_d == FLUSH);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  // State and every output are registered; reset zeroes them all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      address_q <= '0;
      data_in_q <= '0;
      write_q   <= 1'b0;
      rd_q      <= 1'b0;
      flush_q   <= '0;
      seed_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      data_in_q <= data_in_d;
      write_q   <= write_d;
      rd_q      <= rd_d;
      flush_q   <= flush_d;
      seed_q    <= seed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      first_q   <= first_d;
    end
  end

  assign address        = address_q;
  assign dataIn         = data_in_q;
  assign write          = write_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule
